sram_port_arbiter: RTL and testbench

- Arbitrates the single-port 64K x 32 SRAM between two requesters: the CPU control FSM (fetch/LD/ST) and the DMA copy engine.
- CPU has fixed priority, but a starvation guard and a bounded DMA lock let DMA read/write pairs complete.
- Routes 1-cycle-latency read data back to the requester that issued the read.
- Sits between CTL and SP.SRAM; CTL and DMA no longer drive the SRAM pins directly.

---
 rtl/sram_port_arbiter_if.sv | 39 +++
 rtl/sram_port_arbiter.sv | 152 +++++++++++++++
 tb/tb_sram_port_arbiter.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/sram_port_arbiter_if.sv
// Requester and SRAM pin bundle for the SRAM port arbiter.
// slave is the arbiter's view; master is the requester/SRAM side.
interface sram_port_arbiter_if;
  logic        cpu_req;
  logic        cpu_we;
  logic [15:0] cpu_addr;
  logic [31:0] cpu_di;
  logic        cpu_gnt;
  logic        cpu_rvalid;
  logic        dma_req;
  logic        dma_we;
  logic [15:0] dma_addr;
  logic [31:0] dma_di;
  logic        dma_lock;
  logic        dma_gnt;
  logic        dma_rvalid;
  logic [31:0] rdata;
  logic [15:0] sram_ADDR;
  logic [31:0] sram_DI;
  logic        sram_EN;
  logic        sram_WE;
  logic [31:0] sram_DO;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_di,
    input  dma_req, dma_we, dma_addr, dma_di, dma_lock,
    input  sram_DO,
    output cpu_gnt, cpu_rvalid, dma_gnt, dma_rvalid,
    output rdata, sram_ADDR, sram_DI, sram_EN, sram_WE
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_di,
    output dma_req, dma_we, dma_addr, dma_di, dma_lock,
    output sram_DO,
    input  cpu_gnt, cpu_rvalid, dma_gnt, dma_rvalid,
    input  rdata, sram_ADDR, sram_DI, sram_EN, sram_WE
  );
endinterface

// File: rtl/sram_port_arbiter.sv
// CPU/DMA arbiter for the single-port 64K x 32 SRAM.
// Optional SRAM_ARB_STATS_EN adds grant/conflict counters and a trace.
module sram_port_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int LOCK_MAX     = 2
) (
  input  logic clk,
  input  logic reset,
  sram_port_arbiter_if.slave bus
`ifdef SRAM_ARB_STATS_EN
  ,
  output logic [31:0] stat_cpu_grants,
  output logic [31:0] stat_dma_grants,
  output logic [31:0] stat_conflicts
`endif
);

  localparam logic [3:0] SL = 4'(STARVE_LIMIT);
  localparam logic [3:0] LM = 4'(LOCK_MAX);

  typedef enum logic [1:0] {
    ARB_FREE,
    ARB_DMA_LOCK,
    ARB_RELEASE
  } arb_state_e;

  arb_state_e state, state_n;
  logic [3:0] starve_cnt, starve_n;
  logic [3:0] lock_cnt, lock_n;
  logic       cpu_win, dma_win;
  logic       rd_cpu, rd_dma;

  // Pick the winner and the next arbitration state.
  always_comb begin
    cpu_win = 1'b0;
    dma_win = 1'b0;
    state_n = state;
    lock_n  = lock_cnt;
    case (state)
      ARB_FREE: begin
        if (bus.dma_req && (starve_cnt == SL || !bus.cpu_req))
          dma_win = 1'b1;
        else if (bus.cpu_req)
          cpu_win = 1'b1;
        if (dma_win && bus.dma_lock) begin
          state_n = ARB_DMA_LOCK;
          lock_n  = 4'd1;
        end
      end
      ARB_DMA_LOCK: begin
        if (bus.dma_req) begin
          dma_win = 1'b1;
          if (bus.dma_lock && lock_cnt < LM) begin
            lock_n = lock_cnt + 4'd1;
          end else begin
            state_n = ARB_RELEASE;
          end
        end else begin
          cpu_win = bus.cpu_req;
          state_n = ARB_FREE;
          lock_n  = 4'd0;
        end
      end
      ARB_RELEASE: begin
        if (bus.cpu_req)
          cpu_win = 1'b1;
        else if (bus.dma_req)
          dma_win = 1'b1;
        state_n = ARB_FREE;
        lock_n  = 4'd0;
      end
      default: begin
        state_n = ARB_FREE;
        lock_n  = 4'd0;
      end
    endcase
  end

  // Starvation counter: count denied DMA cycles, saturating.
  always_comb begin
    starve_n = starve_cnt;
    if (!bus.dma_req || dma_win)
      starve_n = 4'd0;
    else if (starve_cnt != SL)
      starve_n = starve_cnt + 4'd1;
  end

  // Arbitration state and read-owner tracking.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ARB_FREE;
      starve_cnt <= 4'd0;
      lock_cnt   <= 4'd0;
      rd_cpu     <= 1'b0;
      rd_dma     <= 1'b0;
    end else begin
      state      <= state_n;
      starve_cnt <= starve_n;
      lock_cnt   <= lock_n;
      rd_cpu     <= cpu_win & ~bus.cpu_we;
      rd_dma     <= dma_win & ~bus.dma_we;
    end
  end

  assign bus.cpu_gnt    = cpu_win & ~reset;
  assign bus.dma_gnt    = dma_win & ~reset;
  assign bus.cpu_rvalid = rd_cpu & ~reset;
  assign bus.dma_rvalid = rd_dma & ~reset;
  assign bus.rdata      = bus.sram_DO;

  // Drive the SRAM pins from the winner, idle zeros otherwise.
  always_comb begin
    bus.sram_EN   = 1'b0;
    bus.sram_WE   = 1'b0;
    bus.sram_ADDR = 16'd0;
    bus.sram_DI   = 32'd0;
    unique case (1'b1)
      bus.cpu_gnt: begin
        bus.sram_EN   = 1'b1;
        bus.sram_WE   = bus.cpu_we;
        bus.sram_ADDR = bus.cpu_addr;
        bus.sram_DI   = bus.cpu_di;
      end
      bus.dma_gnt: begin
        bus.sram_EN   = 1'b1;
        bus.sram_WE   = bus.dma_we;
        bus.sram_ADDR = bus.dma_addr;
        bus.sram_DI   = bus.dma_di;
      end
      default: ;
    endcase
  end

`ifdef SRAM_ARB_STATS_EN
  // Free-running grant/conflict counters plus a per-cycle trace line.
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_cpu_grants <= 32'd0;
      stat_dma_grants <= 32'd0;
      stat_conflicts  <= 32'd0;
    end else begin
      stat_cpu_grants <= stat_cpu_grants + {31'd0, bus.cpu_gnt};
      stat_dma_grants <= stat_dma_grants + {31'd0, bus.dma_gnt};
      stat_conflicts  <= stat_conflicts
                       + {31'd0, bus.cpu_req & bus.dma_req};
    end
    $display("arb %s %0b %0b",
             state.name(), bus.cpu_gnt, bus.dma_gnt);
  end
`endif

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed self-checking bench for sram_port_arbiter.
// Includes a behavioural 1-cycle-latency SRAM model.
module tb_sram_port_arbiter;

  logic clk = 1'b0;
  logic reset;
  int   n_pass = 0;
  int   n_total = 0;

  logic [31:0] mem [0:65535];

  sram_port_arbiter_if bus ();

  sram_port_arbiter #(
    .STARVE_LIMIT(4),
    .LOCK_MAX(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.sram_EN) begin
      if (bus.sram_WE)
        mem[bus.sram_ADDR] <= bus.sram_DI;
      else
        bus.sram_DO <= mem[bus.sram_ADDR];
    end
  end

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic cpu_set(input logic req, input logic we,
                         input logic [15:0] a, input logic [31:0] d);
    bus.cpu_req  = req;
    bus.cpu_we   = we;
    bus.cpu_addr = a;
    bus.cpu_di   = d;
  endtask

  task automatic dma_set(input logic req, input logic we,
                         input logic [15:0] a, input logic [31:0] d,
                         input logic lk);
    bus.dma_req  = req;
    bus.dma_we   = we;
    bus.dma_addr = a;
    bus.dma_di   = d;
    bus.dma_lock = lk;
  endtask

  task automatic idle();
    @(negedge clk);
    cpu_set(0, 0, 16'h0, 32'h0);
    dma_set(0, 0, 16'h0, 32'h0, 0);
    #1;
  endtask

  initial begin
    mem[16'h0001] <= 32'h1111_1111;
    mem[16'h0002] <= 32'h2222_2222;
    mem[16'h0003] <= 32'h3333_3333;
    mem[16'h0010] <= 32'hDEAD_BEEF;
    mem[16'h0020] <= 32'hCAFE_F00D;
    mem[16'h0040] <= 32'h0000_0000;
    bus.sram_DO = 32'h0;
    reset = 1'b1;
    cpu_set(1, 0, 16'h0010, 32'h0);
    dma_set(1, 0, 16'h0020, 32'h0, 1);

    // Reset holds all outputs low even with requests present.
    @(negedge clk);
    @(negedge clk);
    #1;
    check("rst_cpu_gnt", {31'd0, bus.cpu_gnt}, 0);
    check("rst_dma_gnt", {31'd0, bus.dma_gnt}, 0);
    check("rst_en", {31'd0, bus.sram_EN}, 0);
    check("rst_addr", {16'd0, bus.sram_ADDR}, 0);
    check("rst_rvalid",
          {30'd0, bus.cpu_rvalid, bus.dma_rvalid}, 0);

    // CPU-only read of 0x0010.
    @(negedge clk);
    reset = 1'b0;
    cpu_set(1, 0, 16'h0010, 32'h0);
    dma_set(0, 0, 16'h0, 32'h0, 0);
    #1;
    check("t1_cpu_gnt", {31'd0, bus.cpu_gnt}, 1);
    check("t1_en_we", {30'd0, bus.sram_EN, bus.sram_WE}, 32'd2);
    check("t1_addr", {16'd0, bus.sram_ADDR}, 32'h10);
    idle();
    check("t1_cpu_rvalid", {31'd0, bus.cpu_rvalid}, 1);
    check("t1_rdata", bus.rdata, 32'hDEAD_BEEF);
    check("t1_dma_rvalid", {31'd0, bus.dma_rvalid}, 0);

    // Both request writes continuously: starvation forces DMA on cycle 4.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      cpu_set(1, 1, 16'h0100, 32'hA5A5_0000);
      dma_set(1, 1, 16'h0101, 32'h5A5A_0000, 0);
      #1;
      check($sformatf("t2_cpu_gnt_%0d", i),
            {31'd0, bus.cpu_gnt}, (i == 4) ? 0 : 1);
      check($sformatf("t2_dma_gnt_%0d", i),
            {31'd0, bus.dma_gnt}, (i == 4) ? 1 : 0);
      check($sformatf("t2_rvalid_%0d", i),
            {30'd0, bus.cpu_rvalid, bus.dma_rvalid}, 0);
    end
    idle();

    // DMA locked read->write copy 0x0020 -> 0x0040 against CPU.
    @(negedge clk);
    cpu_set(0, 0, 16'h0, 32'h0);
    dma_set(1, 0, 16'h0020, 32'h0, 1);
    #1;
    check("t3_rd_dma_gnt", {31'd0, bus.dma_gnt}, 1);
    @(negedge clk);
    check("t3_dma_rvalid", {31'd0, bus.dma_rvalid}, 1);
    cpu_set(1, 1, 16'h0200, 32'h1234_5678);
    dma_set(1, 1, 16'h0040, bus.rdata, 0);
    #1;
    check("t3_wr_dma_gnt", {31'd0, bus.dma_gnt}, 1);
    check("t3_wr_cpu_gnt", {31'd0, bus.cpu_gnt}, 0);
    check("t3_wr_di", bus.sram_DI, 32'hCAFE_F00D);
    @(negedge clk);
    dma_set(0, 0, 16'h0, 32'h0, 0);
    #1;
    check("t3_release_cpu", {31'd0, bus.cpu_gnt}, 1);
    check("t3_copy", mem[16'h0040], 32'hCAFE_F00D);
    idle();

    // DMA holds lock; it keeps the port for 3 cycles, then CPU.
    @(negedge clk);
    cpu_set(0, 0, 16'h0, 32'h0);
    dma_set(1, 0, 16'h0030, 32'h0, 1);
    #1;
    check("t4_dma_0", {31'd0, bus.dma_gnt}, 1);
    for (int i = 1; i < 5; i++) begin
      @(negedge clk);
      cpu_set(1, 1, 16'h0300, 32'h0);
      #1;
      check($sformatf("t4_dma_%0d", i),
            {31'd0, bus.dma_gnt}, (i < 3) ? 1 : 0);
      check($sformatf("t4_cpu_%0d", i),
            {31'd0, bus.cpu_gnt}, (i < 3) ? 0 : 1);
    end
    idle();

    // Alternating reads return in issue order.
    @(negedge clk);
    cpu_set(1, 0, 16'h0001, 32'h0);
    #1;
    check("t5_cpu_gnt", {31'd0, bus.cpu_gnt}, 1);
    @(negedge clk);
    cpu_set(0, 0, 16'h0, 32'h0);
    dma_set(1, 0, 16'h0002, 32'h0, 0);
    #1;
    check("t5_dma_gnt", {31'd0, bus.dma_gnt}, 1);
    check("t5_rv1", {30'd0, bus.cpu_rvalid, bus.dma_rvalid}, 32'd2);
    check("t5_rd1", bus.rdata, 32'h1111_1111);
    @(negedge clk);
    dma_set(0, 0, 16'h0, 32'h0, 0);
    cpu_set(1, 0, 16'h0003, 32'h0);
    #1;
    check("t5_rv2", {30'd0, bus.cpu_rvalid, bus.dma_rvalid}, 32'd1);
    check("t5_rd2", bus.rdata, 32'h2222_2222);
    idle();
    check("t5_rv3", {30'd0, bus.cpu_rvalid, bus.dma_rvalid}, 32'd2);
    check("t5_rd3", bus.rdata, 32'h3333_3333);

    // Reset during a lock with a read outstanding.
    @(negedge clk);
    dma_set(1, 0, 16'h0020, 32'h0, 1);
    #1;
    check("t6_dma_gnt", {31'd0, bus.dma_gnt}, 1);
    @(negedge clk);
    reset = 1'b1;
    cpu_set(1, 0, 16'h0001, 32'h0);
    #1;
    check("t6_rst_gnt", {30'd0, bus.cpu_gnt, bus.dma_gnt}, 0);
    check("t6_rst_rv", {30'd0, bus.cpu_rvalid, bus.dma_rvalid}, 0);
    check("t6_rst_en", {31'd0, bus.sram_EN}, 0);
    @(negedge clk);
    reset = 1'b0;
    dma_set(1, 0, 16'h0020, 32'h0, 0);
    #1;
    check("t6_cpu_wins", {31'd0, bus.cpu_gnt}, 1);
    check("t6_dma_lost", {31'd0, bus.dma_gnt}, 0);
    check("t6_no_rv", {31'd0, bus.dma_rvalid}, 0);
    idle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
